// File: rtl/flit_rx_nic.sv
// flit_rx_nic: receive-side network interface.
// Checks incoming single-flit packets for format and destination, buffers
// accepted payloads in two per-VC FIFOs, and delivers them to the PE through
// a one-stage output register with a valid/ready handshake. Round-robin
// arbitration is used when both VCs hold data.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flit_in       [70] valid, [69] single-flit, [68:65] dest, [64] VC, [63:0] payload
//   credit_out    one-cycle pulse per VC when a slot of that VC is freed
//   data_out      payload to PE; data_vc is the VC it arrived on
//   data_valid    data_out/data_vc hold a payload; data_ready is the PE accept
//   drop_cnt      saturating count of misrouted/malformed flits
//   overflow_err  sticky; a flit arrived for a full VC with no same-cycle pop
module flit_rx_nic #(
  parameter logic [3:0]  NODE_ID = 4'd0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [70:0]      flit_in,
  output logic [1:0]       credit_out,
  output logic [63:0]      data_out,
  output logic             data_vc,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow_err
);

  localparam int unsigned DW = 64;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [1:0][DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [1:0][AW-1:0]            rptr_q, rptr_d;
  logic [1:0][AW-1:0]            wptr_q, wptr_d;
  logic [1:0][CW-1:0]            cnt_q, cnt_d;
  logic                          rr_q, rr_d;
  logic [DW-1:0]                 data_out_q, data_out_d;
  logic                          data_vc_q, data_vc_d;
  logic                          data_valid_q, data_valid_d;
  logic [1:0]                    credit_q, credit_d;
  logic [CNT_W-1:0]              drop_q, drop_d;
  logic                          ovf_q, ovf_d;

  logic                          load_c;
  logic                          win_c;
  logic [1:0]                    ne_c;
  logic [1:0]                    pop_c;
  logic [1:0]                    wr_c;
  logic                          f_vc_c;

  assign f_vc_c = flit_in[64];

  // Arbitration, output register load, ingress checks and FIFO bookkeeping
  always_comb begin
    mem_d        = mem_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    data_out_d   = data_out_q;
    data_vc_d    = data_vc_q;
    data_valid_d = data_valid_q;
    credit_d     = 2'b00;
    drop_d       = drop_q;
    ovf_d        = ovf_q;
    pop_c        = 2'b00;
    wr_c         = 2'b00;

    ne_c[0] = (cnt_q[0] != '0);
    ne_c[1] = (cnt_q[1] != '0);
    load_c  = !data_valid_q || data_ready;
    // Single non-empty VC wins outright; both non-empty defers to the pointer
    win_c   = (ne_c == 2'b11) ? rr_q : ne_c[1];

    // Emptiness uses current counts only, so a same-cycle write never bypasses
    if (load_c) begin
      if (ne_c != 2'b00) begin
        pop_c[win_c]  = 1'b1;
        data_out_d    = mem_q[win_c][rptr_q[win_c]];
        data_vc_d     = win_c;
        data_valid_d  = 1'b1;
        rptr_d[win_c] = rptr_q[win_c] + AW'(1);
        if (ne_c == 2'b11) begin
          rr_d = ~rr_q;
        end
      end else begin
        data_valid_d = 1'b0;
      end
    end
    credit_d = pop_c;

    if (flit_in[70]) begin
      if (!flit_in[69] || (flit_in[68:65] != NODE_ID)) begin
        if (drop_q != {CNT_W{1'b1}}) begin
          drop_d = drop_q + CNT_W'(1);
        end
      end else if ((cnt_q[f_vc_c] < CW'(DEPTH)) || pop_c[f_vc_c]) begin
        wr_c[f_vc_c]                   = 1'b1;
        mem_d[f_vc_c][wptr_q[f_vc_c]]  = flit_in[63:0];
        wptr_d[f_vc_c]                 = wptr_q[f_vc_c] + AW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    for (int v = 0; v < 2; v++) begin
      cnt_d[v] = cnt_q[v] + CW'(wr_c[v]) - CW'(pop_c[v]);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      rr_q         <= 1'b0;
      data_out_q   <= '0;
      data_vc_q    <= 1'b0;
      data_valid_q <= 1'b0;
      credit_q     <= 2'b00;
      drop_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      data_out_q   <= data_out_d;
      data_vc_q    <= data_vc_d;
      data_valid_q <= data_valid_d;
      credit_q     <= credit_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
    end
  end

  assign credit_out   = credit_q;
  assign data_out     = data_out_q;
  assign data_vc      = data_vc_q;
  assign data_valid   = data_valid_q;
  assign drop_cnt     = drop_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_flit_rx_nic.sv
// Testbench for flit_rx_nic: queue-based reference model plus a handshake
// scoreboard, directed scenarios and a randomized soak.
module tb_flit_rx_nic;

  localparam logic [3:0]  NODE_ID = 4'd0;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [70:0]      flit_in;
  logic [1:0]       credit_out;
  logic [63:0]      data_out;
  logic             data_vc;
  logic             data_valid;
  logic             data_ready;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow_err;

  flit_rx_nic #(.NODE_ID(NODE_ID), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .credit_out(credit_out),
    .data_out(data_out), .data_vc(data_vc), .data_valid(data_valid),
    .data_ready(data_ready), .drop_cnt(drop_cnt), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two payload queues, an output slot and a round-robin bit
  logic [63:0] mq0[$];
  logic [63:0] mq1[$];
  logic [64:0] exp_q[$];
  logic        m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  logic        m_vc    = 1'b0;
  logic [1:0]  m_cred  = 2'b00;
  int          m_drop  = 0;
  logic        m_ovf   = 1'b0;
  logic        m_rr    = 1'b0;
  int          mw, s0, s1, fvc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq0.delete(); mq1.delete(); exp_q.delete();
      m_valid = 1'b0; m_data = '0; m_vc = 1'b0; m_cred = 2'b00;
      m_drop = 0; m_ovf = 1'b0; m_rr = 1'b0;
    end else begin
      s0 = mq0.size();
      s1 = mq1.size();
      m_cred = 2'b00;
      mw = -1;
      if (!m_valid || data_ready) begin
        if (s0 > 0 && s1 > 0) begin
          mw = int'(m_rr);
          m_rr = !m_rr;
        end else if (s0 > 0) mw = 0;
        else if (s1 > 0) mw = 1;
        if (mw == 0) m_data = mq0.pop_front();
        if (mw == 1) m_data = mq1.pop_front();
        if (mw >= 0) begin
          m_vc = (mw == 1);
          m_valid = 1'b1;
          m_cred = (mw == 1) ? 2'b10 : 2'b01;
          exp_q.push_back({m_vc, m_data});
        end else begin
          m_valid = 1'b0;
        end
      end
      if (flit_in[70] === 1'b1) begin
        if (!flit_in[69] || flit_in[68:65] != NODE_ID) begin
          if (m_drop < (1 << CNT_W) - 1) m_drop++;
        end else begin
          fvc = flit_in[64] ? 1 : 0;
          if ((fvc == 0 ? s0 : s1) < DEPTH || mw == fvc) begin
            if (fvc == 0) mq0.push_back(flit_in[63:0]);
            else mq1.push_back(flit_in[63:0]);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: register-state checks each cycle, payload scoreboard on handshake
  logic [64:0] got;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("data_valid", 64'(data_valid), 64'(m_valid));
      chk("credit_out", 64'(credit_out), 64'(m_cred));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      chk("data_out_hold", data_out, m_data);
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_payload", 64'(data_valid), 64'(0));
        end else begin
          got = exp_q.pop_front();
          chk("sb_data", data_out, got[63:0]);
          chk("sb_vc", 64'(data_vc), 64'(got[64]));
        end
      end
    end
  end

  function automatic logic [70:0] mk(input logic v, input logic s, input logic [3:0] d,
                                      input logic vc, input logic [63:0] p);
    return {v, s, d, vc, p};
  endfunction

  task automatic send(input logic [70:0] f);
    flit_in = f;
    @(negedge clk);
    flit_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data_valid", 64'(data_valid), 64'(0));
    chk("rst_data_out", data_out, 64'(0));
    chk("rst_data_vc", 64'(data_vc), 64'(0));
    chk("rst_credit", 64'(credit_out), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_ovf", 64'(overflow_err), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]  bad_dst;
  logic [63:0] pay;
  int          r;

  initial begin
    rst_n      = 1'b0;
    flit_in    = '0;
    data_ready = 1'b1;
    bad_dst    = NODE_ID + 4'd1;
    @(negedge clk);
    do_reset();

    // Single good flit on VC0: visible two edges after it is driven
    send(mk(1'b1, 1'b1, NODE_ID, 1'b0, 64'hDEAD_BEEF_0000_0001));
    chk("lat_valid_early", 64'(data_valid), 64'(0));
    @(negedge clk);
    chk("lat_valid", 64'(data_valid), 64'(1));
    chk("lat_data", data_out, 64'hDEAD_BEEF_0000_0001);
    chk("lat_vc", 64'(data_vc), 64'(0));
    chk("lat_credit", 64'(credit_out), 64'(2'b01));
    idle(2);

    // Misrouted and malformed flits are dropped
    send(mk(1'b1, 1'b1, bad_dst, 1'b0, 64'h1111));
    send(mk(1'b1, 1'b0, NODE_ID, 1'b1, 64'h2222));
    idle(2);
    chk("drop_two", 64'(drop_cnt), 64'(2));
    chk("drop_no_valid", 64'(data_valid), 64'(0));

    // Overflow on VC1 with the PE stalled
    data_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(mk(1'b1, 1'b1, NODE_ID, 1'b1, 64'hA000 + 64'(i)));
    chk("ovf_before", 64'(overflow_err), 64'(0));
    send(mk(1'b1, 1'b1, NODE_ID, 1'b1, 64'hAFFF));
    chk("ovf_set", 64'(overflow_err), 64'(1));
    chk("ovf_drop_same", 64'(drop_cnt), 64'(2));
    chk("ovf_out_stable", data_out, 64'hA000);
    data_ready = 1'b1;
    idle(DEPTH + 3);

    // Interleaved fill of both VCs, then drain for arbitration order
    data_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(mk(1'b1, 1'b1, NODE_ID, 1'(i % 2), 64'hB000 + 64'(i)));
    data_ready = 1'b1;
    idle(10);

    // Reset with payloads buffered
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(1'b1, 1'b1, NODE_ID, 1'(i % 2), 64'hC000 + 64'(i)));
    do_reset();
    data_ready = 1'b1;
    idle(3);
    chk("post_rst_valid", 64'(data_valid), 64'(0));
    chk("post_rst_credit", 64'(credit_out), 64'(0));

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      data_ready = ($urandom_range(3) != 0);
      r = $urandom_range(9);
      pay = {$urandom, $urandom};
      flit_in = mk(($urandom_range(9) < 7), (r != 0), (r == 1) ? bad_dst : NODE_ID,
                   1'($urandom_range(1)), pay);
      @(negedge clk);
    end
    flit_in = '0;
    data_ready = 1'b1;
    idle(2 * DEPTH + 4);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) send(mk(1'b1, 1'b1, bad_dst, 1'b0, 64'(i)));
    idle(2);
    chk("drop_saturated", 64'(drop_cnt), 64'(255));

    idle(4);
    chk("drained_valid", 64'(data_valid), 64'(0));
    chk("drained_queue", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
